// File: rtl/fetch_unit_pkg.sv
// Shared processor definitions: PCSrc encodings, fetch FSM states, reset vector.
// TRAP state exists only when FETCH_ALIGN_CHECK_EN is defined.
package fetch_unit_pkg;

  localparam logic [1:0] PC_BRANCH = 2'b00;
  localparam logic [1:0] PC_REG    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SEQ    = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID
`ifdef FETCH_ALIGN_CHECK_EN
    , S_TRAP
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_sel.sv
// Combinational next-PC target selection for the fetch stage.
module next_pc_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] rs_value,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;

  // imm16 counts words, so the byte offset is sign-extended and scaled by 4
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      PC_BRANCH: next_pc = pc_plus4 + branch_off;
      PC_REG:    next_pc = rs_value;
      PC_JUMP:   next_pc = {pc_plus4[31:28], jtarget, 2'b00};
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem req/ready handshake, commit counter.
// Optional FETCH_ALIGN_CHECK_EN adds a sticky misalign flag and a TRAP state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  PCSrc,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  input  logic [31:0] rs_value,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        misalign,
`endif
  output logic [31:0] instret
);

  fetch_state_e state_q, state_d;
  logic [31:0]  next_pc_raw, next_pc;
  logic         load_instr, commit;
`ifdef FETCH_ALIGN_CHECK_EN
  logic         trap;
`endif

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign next_pc   = next_pc_raw & 32'hFFFF_FFFC;

  next_pc_sel u_next_pc_sel (
    .pc_plus4 (pc_plus4),
    .PCSrc    (PCSrc),
    .imm16    (imm16),
    .jtarget  (jtarget),
    .rs_value (rs_value),
    .next_pc  (next_pc_raw)
  );

  always_comb begin
    state_d     = state_q;
    load_instr  = 1'b0;
    commit      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    trap        = 1'b0;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          load_instr = 1'b1;
          state_d    = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc_raw[1:0] != 2'b00) begin
            trap    = 1'b1;
            state_d = S_TRAP;
          end else begin
            commit  = 1'b1;
            state_d = S_REQ;
          end
`else
          commit  = 1'b1;
          state_d = S_REQ;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc       <= RESET_PC;
      instr    <= '0;
      instret  <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (load_instr) instr <= imem_rdata;
      if (commit) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      if (trap) misalign <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle processor. It sits directly upstream of the opcode decoder and control block.
- Holds the program counter and fetches each instruction from instruction memory over a req/ready handshake.
- Presents the instruction word to the decoder.
- Takes the decoder's `PCSrc` decision plus branch/jump operands to select the next PC when the datapath commits the instruction.
- Counts committed instructions.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded at reset; must be word-aligned.
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `PCSrc` input 2: next-PC select from control.
  - 00 = branch target
  - 01 = register target
  - 10 = jump target
  - 11 = PC+4
- `imm16` input 16: branch offset, in words, signed.
- `jtarget` input 26: jump target field.
- `rs_value` input 32: register-file operand for register target.
- `advance` input 1: datapath commits the current instruction this cycle.
- `imem_req` output 1: fetch request to instruction memory.
- `imem_addr` output 32: fetch address.
- `imem_ready` input 1: instruction memory returns `imem_rdata` this cycle.
- `imem_rdata` input 32: fetched word.
- `instr` output 32: current instruction word to the decoder.
- `instr_valid` output 1: `instr` is valid and awaiting commit.
- `pc` output 32: address of the current instruction.
- `pc_plus4` output 32: `pc` + 4.
- `instret` output 32: committed-instruction counter.
- `misalign` output 1: sticky misaligned-target flag. Present only with `FETCH_ALIGN_CHECK_EN`.

## Operation
- FSM states: IDLE, REQ, VALID, and TRAP (TRAP only with the macro).
- Reset values:
  - state = IDLE, `pc` = `RESET_PC`, `instr` = 0, `instret` = 0.
  - `instr_valid` = 0, `imem_req` = 0, `misalign` = 0.
- IDLE: always moves to REQ on the next clock.
- REQ:
  - `imem_req` = 1 and `imem_addr` = `pc`; both held stable until `imem_ready`.
  - On `imem_ready`: `instr` <= `imem_rdata`, go to VALID.
- VALID:
  - `instr_valid` = 1.
  - On `advance`: `pc` <= next_pc, `instret` += 1, go to REQ.
- next_pc (combinational, sampled only on `advance` in VALID):
  - 11: `pc_plus4`.
  - 00: `pc_plus4` + sign-extended (`imm16` << 2).
  - 10: {`pc_plus4`[31:28], `jtarget`, 2'b00}.
  - 01: `rs_value`.
- Arithmetic is 32-bit modular: PC 32'hFFFF_FFFC + 4 = 0; branch sums wrap silently.
- `instret` wraps from 32'hFFFF_FFFF to 0.
- Ignored inputs:
  - `advance` outside VALID.
  - `imem_ready` outside REQ.
  - `PCSrc`/operands outside the `advance` cycle.
- Reset asserted mid-fetch drops `imem_req` immediately (asynchronously); any in-flight memory response is discarded.

## Timing
- First `imem_req` is asserted in the second rising edge after `rst` deasserts (one IDLE cycle).
- Fetch latency: `instr_valid` rises the cycle after the `imem_ready` cycle.
- Commit-to-fetch: `imem_req` with the new `imem_addr` is asserted the cycle after `advance`.
- Minimum throughput is 2 cycles per instruction (REQ + VALID), when `imem_ready` is asserted in the first REQ cycle and `advance` in the first VALID cycle.
- `pc`, `pc_plus4`, and `instr` are stable for the whole VALID period.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - If `advance` is sampled with next_pc[1:0] != 0, go to TRAP instead.
  - `pc` and `instret` are not updated; `misalign` is set.
  - In TRAP, `imem_req` and `instr_valid` are 0. TRAP is left only by `rst`.
- Not defined:
  - next_pc[1:0] is forced to 2'b00; there is no TRAP state and no `misalign` port.

## Structure
- Shared processor package holds:
  - `PCSrc` encodings as named constants (PC_BRANCH, PC_REG, PC_JUMP, PC_SEQ).
  - The FSM state typedef.
  - The default reset vector constant.
- One sub-module, `next_pc_sel`: purely combinational target computation from `pc_plus4`, `PCSrc`, `imm16`, `jtarget`, `rs_value`. The FSM, PC register and counter stay in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0x100 and `imem_ready` tied 1 → `imem_addr`=0x100 in the second edge after reset; `instr_valid` next cycle; `instret`=0.
- Five sequential commits (`PCSrc`=11) → `pc` steps 0x100, 0x104, …, 0x114; `instret`=5; instruction every 2 cycles.
- Branch at `pc`=0x200, `imm16`=16'hFFFE → next `imem_addr`=0x1FC. Jump at 0x3000_0010, `jtarget`=26'h40 → 0x3000_0100.
- `imem_ready` delayed 3 cycles → `imem_req`/`imem_addr` stable throughout; `advance` pulses during REQ ignored; `instret` unchanged.
- `PCSrc`=01, `rs_value`=0x0000_0402 → with macro: TRAP, `misalign`=1, no further `imem_req`. Without macro: `imem_addr`=0x400.
- Wrap and reset cases:
  - `pc`=0xFFFF_FFFC with `PCSrc`=11 → next `imem_addr`=0.
  - `rst` pulsed during REQ → `imem_req` drops same cycle; refetch from `RESET_PC`.
